immgen_stage: RTL and testbench
===============================

# immgen_stage

Registered, handshaked immediate-generation stage for the pipelined RV32I/RV64I core, sitting between fetch and the execute-side operand mux. It decodes the immediate of every base-ISA format, including the CSR zimm field, sign-extends it to a parametrised width, and computes the PC-relative target `pc + imm`. Results are buffered in a two-entry skid buffer so that full throughput is kept under back-pressure, and the whole stage flushes synchronously.

## Interface
Parameters:
- `XLEN`, 32: datapath width. Legal values are 32 and 64.

Ports:
- `clk_i`, in, 1: the single clock.
- `rst_i`, in, 1: reset, synchronous and active-high.
- `flush_i`, in, 1: synchronous pipeline flush.
- `in_valid_i`, in, 1: the upstream holds a valid instruction.
- `in_ready_o`, out, 1: the stage can accept an instruction this cycle.
- `instr_i`, in, 32: raw instruction.
- `pc_i`, in, XLEN: PC of `instr_i`.
- `out_valid_o`, out, 1: the output fields are valid.
- `out_ready_i`, in, 1: downstream accepts the output.
- `imm_o`, out, XLEN: the sign- or zero-extended immediate.
- `target_o`, out, XLEN: `pc + imm_o`, modulo 2^XLEN.
- `pc_o`, out, XLEN: PC of the output instruction.
- `fmt_o`, out, 3: immediate format code (`imm_fmt_e`).
- `illegal_o`, out, 1: the opcode is unrecognised, or `instr[1:0]` is not `11`.

## Operation
Decode is selected by `instr[6:2]`, with `instr[1:0]` required to be `11`:
- **I-format** (load `00000`, OP-IMM `00100`, JALR `11001`, and OP-IMM-32 `00110` when XLEN=64 only): `sext(instr[31:20])`. All I-format immediates are sign-extended, loads included.
- **S-format** (`01000`): `sext({instr[31:25], instr[11:7]})`.
- **B-format** (`11000`): `sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})`.
- **J-format** (`11011`): `sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})`.
- **U-format** (LUI `01101`, AUIPC `00101`): `sext({instr[31:12], 12'b0})`. The upper bits are sign-extended when XLEN=64.
- **SYSTEM** (`11100`):
  - When `funct3[2]`=1: zimm format, `zext(instr[19:15])`.
  - Otherwise: I-format.
- **R-type** (OP `01100`; OP-32 `01110` when XLEN=64): format NONE, `imm_o`=0, `illegal_o`=0.
- **Anything else**, including OP-IMM-32 and OP-32 when XLEN=32: format NONE, `imm_o`=0, `illegal_o`=1.
- The format codes are NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6.
- `target_o` is always `pc + imm` with wrap-around, regardless of format.

Skid buffer:
- The buffer holds an output register (OUT) and a skid register (SKID).
- The state machine has three states:
  - EMPTY: both registers empty.
  - ONE: OUT valid.
  - FULL: OUT and SKID both valid.
- `in_ready_o` = (state != FULL). It depends only on registered state and never combinationally on `out_ready_i`.
- `out_valid_o` = (state != EMPTY).
- Accept = `in_valid_i & in_ready_o`. Drain = `out_valid_o & out_ready_i`.
- State transitions:
  - EMPTY → ONE on accept.
  - ONE → ONE on accept & drain.
  - ONE → FULL on accept & !drain.
  - ONE → EMPTY on drain & !accept.
  - FULL → ONE on drain, which moves SKID to OUT.
  - In all other cases the state holds.
- Output fields are stable while `out_valid_o` is high and `out_ready_i` is low.
- Instructions leave in acceptance order.
- Flush:
  - When `flush_i` is high, the next state is EMPTY. Any accept or drain in that cycle is discarded; the upstream sees it as consumed.
  - Flush takes priority over all handshakes.
- Reset:
  - `rst_i` has priority over flush.
  - The state becomes EMPTY. OUT and SKID data are cleared to 0.
  - All outputs read 0, except `in_ready_o`, which reads 1 from the first cycle after reset.
  - Reset asserted mid-transfer drops both buffered entries.

## Timing
- Latency is one cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Sustained throughput is one instruction per cycle while `out_ready_i`=1.
- With `out_ready_i` held low, exactly two instructions are absorbed, and `in_ready_o` falls in the cycle after the second accept.
- The decode and adder sit between the input and the register. There is no combinational path from any input to any output.

## Structure
- `immgen_pkg` holds:
  - `imm_fmt_e` (3-bit enum);
  - the opcode localparams `OPC_LOAD`, `OPC_OPIMM`, `OPC_OPIMM32`, `OPC_STORE`, `OPC_BRANCH`, `OPC_JALR`, `OPC_JAL`, `OPC_LUI`, `OPC_AUIPC`, `OPC_SYSTEM`, `OPC_OP`, `OPC_OP32`;
  - the skid state enum `skid_state_e`.
- One sub-module, `imm_decode`: purely combinational, parametrised on XLEN. It takes `instr` and produces `imm`, `fmt` and `illegal`.
- The adder and the skid buffer live in the top module.

## Test plan
1. **I-format**: XLEN=32, `0xFFF00093` (addi x1,x0,-1) at PC `0x100` → `imm_o`=`0xFFFFFFFF`, fmt I, `target_o`=`0x000000FF`.
2. **S and U formats**: `0xFE112E23` (sw x1,-4(x2)) → `imm_o`=`0xFFFFFFFC`, fmt S. `0x123452B7` (lui) → `0x12345000`, fmt U. With XLEN=64, `0x800002B7` → `0xFFFFFFFF80000000`.
3. **J and Z formats**: `0x001000EF` (jal x1,+2048) at PC `0x100` → `imm_o`=`0x800`, `target_o`=`0x900`, fmt J. `0x3002D073` (csrrwi) → `imm_o`=5, fmt Z. `0x00000000` → `illegal_o`=1, `imm_o`=0.
4. **Back-pressure**: hold `out_ready_i`=0 and offer A, B, C back-to-back → A and B are accepted, and `in_ready_o`=0 while C is held. Then release `out_ready_i` → A, B, C are output in order, each stable until drained.
5. **Flush**: with state FULL, assert `flush_i` for one cycle with `in_valid_i`=1 → next cycle `out_valid_o`=0 and `in_ready_o`=1, and the offered instruction never appears. Reset mid-stream → all outputs read 0, and the pipeline then resumes at full rate.
6. **Throughput and wrap**: stream 8 instructions with `out_ready_i`=1 → one output per cycle after one cycle of latency. PC `0xFFFFFFFC` with B-offset +8 → `target_o`=`0x00000004`.

Source files
------------

// File: rtl/immgen_pkg.sv
// Shared types and constants for the immediate-generation stage.
//   imm_fmt_e    : immediate format code presented on fmt_o
//   OPC_*        : major opcodes, instr[6:2]
//   skid_state_e : occupancy of the two-entry output skid buffer
package immgen_pkg;

    typedef enum logic [2:0] {
        FmtNone = 3'd0,
        FmtI    = 3'd1,
        FmtS    = 3'd2,
        FmtB    = 3'd3,
        FmtU    = 3'd4,
        FmtJ    = 3'd5,
        FmtZ    = 3'd6
    } imm_fmt_e;

    localparam logic [4:0] OPC_LOAD    = 5'b00000;
    localparam logic [4:0] OPC_OPIMM   = 5'b00100;
    localparam logic [4:0] OPC_OPIMM32 = 5'b00110;
    localparam logic [4:0] OPC_STORE   = 5'b01000;
    localparam logic [4:0] OPC_BRANCH  = 5'b11000;
    localparam logic [4:0] OPC_JALR    = 5'b11001;
    localparam logic [4:0] OPC_JAL     = 5'b11011;
    localparam logic [4:0] OPC_LUI     = 5'b01101;
    localparam logic [4:0] OPC_AUIPC   = 5'b00101;
    localparam logic [4:0] OPC_SYSTEM  = 5'b11100;
    localparam logic [4:0] OPC_OP      = 5'b01100;
    localparam logic [4:0] OPC_OP32    = 5'b01110;

    typedef enum logic [1:0] {
        SkidEmpty = 2'd0,
        SkidOne   = 2'd1,
        SkidFull  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder for RV32I/RV64I base formats.
//   instr_i   : raw 32-bit instruction
//   imm_o     : immediate, sign-extended to XLEN (zimm is zero-extended)
//   fmt_o     : decoded immediate format
//   illegal_o : unknown opcode or instr[1:0] != 2'b11
module imm_decode
    import immgen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o,
    output logic            illegal_o
);

    localparam bit Rv64 = (XLEN == 64);

    logic [4:0]  opc;
    logic [31:0] imm32;

    assign opc = instr_i[6:2];

    always_comb begin
        fmt_o     = FmtNone;
        illegal_o = 1'b0;
        if (instr_i[1:0] != 2'b11) begin
            illegal_o = 1'b1;
        end else begin
            case (opc)
                OPC_LOAD, OPC_OPIMM, OPC_JALR: fmt_o = FmtI;
                OPC_OPIMM32: begin
                    if (Rv64) fmt_o = FmtI;
                    else      illegal_o = 1'b1;
                end
                OPC_STORE:          fmt_o = FmtS;
                OPC_BRANCH:         fmt_o = FmtB;
                OPC_JAL:            fmt_o = FmtJ;
                OPC_LUI, OPC_AUIPC: fmt_o = FmtU;
                // funct3[2] selects the immediate CSR forms (rs1 field is zimm)
                OPC_SYSTEM:         fmt_o = instr_i[14] ? FmtZ : FmtI;
                OPC_OP:             illegal_o = 1'b0;
                OPC_OP32:           illegal_o = !Rv64;
                default:            illegal_o = 1'b1;
            endcase
        end
    end

    // Build every immediate as a signed 32-bit value, then widen once.
    always_comb begin
        case (fmt_o)
            FmtI:    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            FmtS:    imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FmtB:    imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
            FmtU:    imm32 = {instr_i[31:12], 12'b0};
            FmtJ:    imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            FmtZ:    imm32 = {27'b0, instr_i[19:15]};
            default: imm32 = 32'b0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/immgen_stage.sv
// Registered, handshaked immediate-generation stage.
//   clk_i, rst_i (sync, active-high), flush_i (sync)
//   in_valid_i/in_ready_o   : upstream handshake, instr_i + pc_i
//   out_valid_o/out_ready_i : downstream handshake
//   imm_o, target_o (pc+imm), pc_o, fmt_o, illegal_o : registered results
// Decode and adder feed a two-entry skid buffer; in_ready_o depends only on
// registered state so no input reaches any output combinationally.
module immgen_stage
    import immgen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] target_o,
    output logic [XLEN-1:0] pc_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        imm_fmt_e        fmt;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;
    entry_t          in_entry;
    entry_t          out_q;
    entry_t          skid_q;
    skid_state_e     state_q;
    logic            accept;
    logic            drain;

    imm_decode #(
        .XLEN (XLEN)
    ) u_imm_decode (
        .instr_i   (instr_i),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        in_entry.imm     = dec_imm;
        in_entry.target  = pc_i + dec_imm;
        in_entry.pc      = pc_i;
        in_entry.fmt     = dec_fmt;
        in_entry.illegal = dec_illegal;
    end

    assign in_ready_o  = (state_q != SkidFull);
    assign out_valid_o = (state_q != SkidEmpty);
    assign accept      = in_valid_i & in_ready_o;
    assign drain       = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SkidEmpty;
            out_q   <= '0;
            skid_q  <= '0;
        end else if (flush_i) begin
            // Data is left stale; out_valid_o low masks it.
            state_q <= SkidEmpty;
        end else begin
            case (state_q)
                SkidEmpty: begin
                    if (accept) begin
                        out_q   <= in_entry;
                        state_q <= SkidOne;
                    end
                end
                SkidOne: begin
                    if (accept && drain) begin
                        out_q <= in_entry;
                    end else if (accept) begin
                        skid_q  <= in_entry;
                        state_q <= SkidFull;
                    end else if (drain) begin
                        state_q <= SkidEmpty;
                    end
                end
                SkidFull: begin
                    // No accept is possible here: in_ready_o is low.
                    if (drain) begin
                        out_q   <= skid_q;
                        state_q <= SkidOne;
                    end
                end
                default: state_q <= SkidEmpty;
            endcase
        end
    end

    assign imm_o     = out_q.imm;
    assign target_o  = out_q.target;
    assign pc_o      = out_q.pc;
    assign fmt_o     = out_q.fmt;
    assign illegal_o = out_q.illegal;

endmodule

// File: tb/tb_immgen_stage.sv
// Bench for immgen_stage: a 32-bit and a 64-bit instance run in lockstep on
// shared control/instruction inputs, checked against a queue-based model.
module tb_immgen_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm32;
        logic [31:0] tgt32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [63:0] tgt64;
        logic [2:0]  fmt64;
        logic        ill64;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc32;
        logic [31:0] imm32;
        logic [31:0] tgt32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] pc64;
        logic [63:0] imm64;
        logic [63:0] tgt64;
        logic [2:0]  fmt64;
        logic        ill64;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] pc32;
    logic [63:0] pc64;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm32, target32, pco32;
    logic [2:0]  fmt32;
    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64, target64, pco64;
    logic [2:0]  fmt64;

    int   n_vec;
    int   n_bad;
    exp_t q[$];
    vec_t tbl[13];

    immgen_stage #(.XLEN(32)) u_dut32 (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready32),
        .instr_i     (instr),
        .pc_i        (pc32),
        .out_valid_o (out_valid32),
        .out_ready_i (out_ready),
        .imm_o       (imm32),
        .target_o    (target32),
        .pc_o        (pco32),
        .fmt_o       (fmt32),
        .illegal_o   (illegal32)
    );

    immgen_stage #(.XLEN(64)) u_dut64 (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready64),
        .instr_i     (instr),
        .pc_i        (pc64),
        .out_valid_o (out_valid64),
        .out_ready_i (out_ready),
        .imm_o       (imm64),
        .target_o    (target64),
        .pc_o        (pco64),
        .fmt_o       (fmt64),
        .illegal_o   (illegal64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [63:0] sext(input logic [63:0] v, input int n);
        logic signed [63:0] s;
        s = $signed(v << (64 - n));
        return s >>> (64 - n);
    endfunction

    // Reference decode straight from the format rules.
    function automatic void ref_decode(input logic [31:0] ins, input bit rv64,
                                       output logic [63:0] imm, output logic [2:0] fmt,
                                       output logic ill);
        imm = 64'd0;
        fmt = 3'd0;
        ill = 1'b0;
        if (ins[1:0] != 2'b11) begin
            ill = 1'b1;
            return;
        end
        case (ins[6:2])
            5'b00000, 5'b00100, 5'b11001: begin fmt = 3'd1; imm = sext(64'(ins[31:20]), 12); end
            5'b00110: begin
                if (rv64) begin fmt = 3'd1; imm = sext(64'(ins[31:20]), 12); end
                else ill = 1'b1;
            end
            5'b01000: begin fmt = 3'd2; imm = sext(64'({ins[31:25], ins[11:7]}), 12); end
            5'b11000: begin
                fmt = 3'd3;
                imm = sext(64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
            end
            5'b11011: begin
                fmt = 3'd5;
                imm = sext(64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
            end
            5'b01101, 5'b00101: begin fmt = 3'd4; imm = sext(64'(ins[31:12]) * 4096, 32); end
            5'b11100: begin
                if (ins[14]) begin fmt = 3'd6; imm = 64'(ins[19:15]); end
                else begin fmt = 3'd1; imm = sext(64'(ins[31:20]), 12); end
            end
            5'b01100: ill = 1'b0;
            5'b01110: ill = !rv64;
            default:  ill = 1'b1;
        endcase
    endfunction

    function automatic exp_t make_exp(input logic [31:0] ins, input logic [31:0] p32,
                                      input logic [63:0] p64);
        exp_t e;
        logic [63:0] im;
        logic [2:0]  f;
        logic        il;
        e.instr = ins;
        e.pc32  = p32;
        e.pc64  = p64;
        ref_decode(ins, 1'b0, im, f, il);
        e.imm32 = im[31:0];
        e.tgt32 = p32 + im[31:0];
        e.fmt32 = f;
        e.ill32 = il;
        ref_decode(ins, 1'b1, im, f, il);
        e.imm64 = im;
        e.tgt64 = p64 + im;
        e.fmt64 = f;
        e.ill64 = il;
        return e;
    endfunction

    function automatic void check_model();
        chk("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
        chk("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
        chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
        chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("imm32", 64'(imm32), 64'(q[0].imm32));
            chk("target32", 64'(target32), 64'(q[0].tgt32));
            chk("pc32", 64'(pco32), 64'(q[0].pc32));
            chk("fmt32", 64'(fmt32), 64'(q[0].fmt32));
            chk("illegal32", 64'(illegal32), 64'(q[0].ill32));
            chk("imm64", imm64, q[0].imm64);
            chk("target64", target64, q[0].tgt64);
            chk("pc64", pco64, q[0].pc64);
            chk("fmt64", 64'(fmt64), 64'(q[0].fmt64));
            chk("illegal64", 64'(illegal64), 64'(q[0].ill64));
        end
    endfunction

    function automatic void model_update();
        bit acc;
        acc = in_valid && (q.size() < 2);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (out_ready && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back(make_exp(instr, pc32, pc64));
        end
    endfunction

    task automatic step();
        check_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] p);
        in_valid = 1'b1;
        instr    = ins;
        pc32     = p;
        pc64     = 64'(p);
    endtask

    function automatic void check_zero(input string tag);
        chk({tag, "_valid32"}, 64'(out_valid32), 64'd0);
        chk({tag, "_ready32"}, 64'(in_ready32), 64'd1);
        chk({tag, "_imm32"}, 64'(imm32), 64'd0);
        chk({tag, "_tgt32"}, 64'(target32), 64'd0);
        chk({tag, "_pc32"}, 64'(pco32), 64'd0);
        chk({tag, "_fmt32"}, 64'(fmt32), 64'd0);
        chk({tag, "_ill32"}, 64'(illegal32), 64'd0);
        chk({tag, "_valid64"}, 64'(out_valid64), 64'd0);
        chk({tag, "_imm64"}, imm64, 64'd0);
        chk({tag, "_tgt64"}, target64, 64'd0);
        chk({tag, "_pc64"}, pco64, 64'd0);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  ops[14];
        logic [31:0] r;
        logic [1:0]  lo;
        ops = '{5'b00000, 5'b00100, 5'b00110, 5'b01000, 5'b11000, 5'b11001, 5'b11011,
                5'b01101, 5'b00101, 5'b11100, 5'b01100, 5'b01110, 5'b11111, 5'b00010};
        r  = $urandom();
        lo = ($urandom_range(15) == 0) ? 2'($urandom()) : 2'b11;
        return {r[31:7], ops[$urandom_range(13)], lo};
    endfunction

    initial begin
        int cnt;
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = 32'd0;
        pc32      = 32'd0;
        pc64      = 64'd0;

        tbl[0]  = '{32'hFFF00093, 32'h100, 32'hFFFFFFFF, 32'hFF, 3'd1, 1'b0,
                    64'hFFFFFFFFFFFFFFFF, 64'hFF, 3'd1, 1'b0};
        tbl[1]  = '{32'hFE112E23, 32'h200, 32'hFFFFFFFC, 32'h1FC, 3'd2, 1'b0,
                    64'hFFFFFFFFFFFFFFFC, 64'h1FC, 3'd2, 1'b0};
        tbl[2]  = '{32'h123452B7, 32'h0, 32'h12345000, 32'h12345000, 3'd4, 1'b0,
                    64'h12345000, 64'h12345000, 3'd4, 1'b0};
        tbl[3]  = '{32'h800002B7, 32'h10, 32'h80000000, 32'h80000010, 3'd4, 1'b0,
                    64'hFFFFFFFF80000000, 64'hFFFFFFFF80000010, 3'd4, 1'b0};
        tbl[4]  = '{32'h001000EF, 32'h100, 32'h800, 32'h900, 3'd5, 1'b0,
                    64'h800, 64'h900, 3'd5, 1'b0};
        tbl[5]  = '{32'h3002D073, 32'h100, 32'h5, 32'h105, 3'd6, 1'b0,
                    64'h5, 64'h105, 3'd6, 1'b0};
        tbl[6]  = '{32'h00000000, 32'h40, 32'h0, 32'h40, 3'd0, 1'b1,
                    64'h0, 64'h40, 3'd0, 1'b1};
        tbl[7]  = '{32'h00000463, 32'hFFFFFFFC, 32'h8, 32'h4, 3'd3, 1'b0,
                    64'h8, 64'h100000004, 3'd3, 1'b0};
        tbl[8]  = '{32'h003100B3, 32'h8, 32'h0, 32'h8, 3'd0, 1'b0,
                    64'h0, 64'h8, 3'd0, 1'b0};
        tbl[9]  = '{32'h0000003B, 32'h20, 32'h0, 32'h20, 3'd0, 1'b1,
                    64'h0, 64'h20, 3'd0, 1'b0};
        tbl[10] = '{32'hFFF0009B, 32'h100, 32'h0, 32'h100, 3'd0, 1'b1,
                    64'hFFFFFFFFFFFFFFFF, 64'hFF, 3'd1, 1'b0};
        tbl[11] = '{32'hFFF00090, 32'h30, 32'h0, 32'h30, 3'd0, 1'b1,
                    64'h0, 64'h30, 3'd0, 1'b1};
        tbl[12] = '{32'h30029073, 32'h0, 32'h300, 32'h300, 3'd1, 1'b0,
                    64'h300, 64'h300, 3'd1, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_zero("reset");

        // Directed decode vectors, streamed back-to-back.
        for (int i = 0; i < 13; i++) begin
            offer(tbl[i].instr, tbl[i].pc);
            step();
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid32), 64'd1);
            chk($sformatf("tbl%0d_imm32", i), 64'(imm32), 64'(tbl[i].imm32));
            chk($sformatf("tbl%0d_tgt32", i), 64'(target32), 64'(tbl[i].tgt32));
            chk($sformatf("tbl%0d_fmt32", i), 64'(fmt32), 64'(tbl[i].fmt32));
            chk($sformatf("tbl%0d_ill32", i), 64'(illegal32), 64'(tbl[i].ill32));
            chk($sformatf("tbl%0d_imm64", i), imm64, tbl[i].imm64);
            chk($sformatf("tbl%0d_tgt64", i), target64, tbl[i].tgt64);
            chk($sformatf("tbl%0d_fmt64", i), 64'(fmt64), 64'(tbl[i].fmt64));
            chk($sformatf("tbl%0d_ill64", i), 64'(illegal64), 64'(tbl[i].ill64));
        end
        in_valid = 1'b0;
        step();

        // Back-pressure: A and B absorbed, C held off until the sink drains.
        out_ready = 1'b0;
        offer(32'h00100093, 32'h1000); step();
        offer(32'h00200093, 32'h1004); step();
        offer(32'h00300093, 32'h1008); step();
        step();
        chk("bp_in_ready", 64'(in_ready32), 64'd0);
        chk("bp_head_imm", 64'(imm32), 64'd1);
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        repeat (3) step();

        // Flush while full with a new instruction offered.
        out_ready = 1'b0;
        offer(32'h00400093, 32'h2000); step();
        offer(32'h00500093, 32'h2004); step();
        flush = 1'b1;
        offer(32'h00600093, 32'h2008);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid32), 64'd0);
        chk("flush_ready", 64'(in_ready32), 64'd1);
        out_ready = 1'b1;
        repeat (2) step();

        // Reset mid-stream, then full-rate streaming.
        out_ready = 1'b0;
        offer(32'hFFF00093, 32'h3000); step();
        offer(32'h001000EF, 32'h3004); step();
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        check_zero("midrst");
        out_ready = 1'b1;
        cnt       = 0;
        for (int i = 0; i < 8; i++) begin
            offer(rand_instr(), $urandom());
            step();
            if (out_valid32) cnt++;
        end
        in_valid = 1'b0;
        step();
        chk("throughput", 64'(cnt), 64'd8);

        // Random traffic with flushes and occasional resets.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(24) == 0);
            rst       = ($urandom_range(99) == 0);
            instr     = rand_instr();
            pc32      = $urandom();
            pc64      = {$urandom(), $urandom()};
            step();
        end
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
